ram_fill_ctrl: RTL and testbench

- Parametrised successor to the fixed 256x8 RAM initialiser: fills, or verifies, any contiguous window of a single-port RAM.
- Supports three patterns: constant, incrementing, and LFSR pseudo-random (GA population seeding).
- Sits between top-level control (keys/switches or the GA sequencer) and the single-port RAM macro; owns the RAM address/data/wren bus while busy.

---
 rtl/ram_fill_pkg.sv | 61 ++++++
 rtl/ram_fill_ctrl_pattern.sv | 45 ++++
 rtl/ram_fill_ctrl.sv | 142 ++++++++++++++
 tb/tb_ram_fill_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fill_pkg.sv
// Shared types and LFSR helpers for the RAM fill/verify controller.
// Tap masks are for a right-shifting Galois LFSR.
package ram_fill_pkg;

   typedef enum logic [1:0] {
      MODE_CONST = 2'd0,
      MODE_INCR  = 2'd1,
      MODE_LFSR  = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FINISH
   } state_e;

   function automatic logic [31:0] lfsr_taps(input int width);
      logic [31:0] t;
      case (width)
         4:       t = 32'h0000_000C;
         5:       t = 32'h0000_0014;
         6:       t = 32'h0000_0030;
         7:       t = 32'h0000_0060;
         8:       t = 32'h0000_00B8;
         9:       t = 32'h0000_0110;
         10:      t = 32'h0000_0240;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0829;
         13:      t = 32'h0000_100D;
         14:      t = 32'h0000_2015;
         15:      t = 32'h0000_6000;
         16:      t = 32'h0000_D008;
         17:      t = 32'h0001_2000;
         18:      t = 32'h0002_0400;
         19:      t = 32'h0004_0023;
         20:      t = 32'h0009_0000;
         21:      t = 32'h0014_0000;
         22:      t = 32'h0030_0000;
         23:      t = 32'h0042_0000;
         24:      t = 32'h00E1_0000;
         25:      t = 32'h0120_0000;
         26:      t = 32'h0200_0023;
         27:      t = 32'h0400_0013;
         28:      t = 32'h0900_0000;
         29:      t = 32'h1400_0000;
         30:      t = 32'h2000_0029;
         31:      t = 32'h4800_0000;
         default: t = 32'h8020_0003;
      endcase
      return t;
   endfunction

   function automatic logic [31:0] lfsr_next(
      input logic [31:0] state,
      input logic [31:0] taps
   );
      return (state >> 1) ^ (state[0] ? taps : 32'h0);
   endfunction

endpackage

// File: rtl/ram_fill_ctrl_pattern.sv
// Data pattern generator: constant, incrementing or Galois LFSR.
// load latches mode and start value; advance steps to the next word.
module ram_fill_pattern
   import ram_fill_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] LFSR_SEED = 'h1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] data
);

   localparam logic [31:0] TAPS = lfsr_taps(DATA_W);

   logic [1:0]        mode_r;
   logic [DATA_W-1:0] step;

   always_comb begin
      step = data;
      case (mode_r)
         MODE_INCR: step = data + DATA_W'(1);
         MODE_LFSR: step = DATA_W'(lfsr_next(32'(data), TAPS));
         default:   step = data;
      endcase
   end

   // a zero seed would lock the LFSR, so it falls back to LFSR_SEED
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_r <= '0;
         data   <= '0;
      end else if (load) begin
         mode_r <= mode;
         data   <= (mode == MODE_LFSR && value == '0) ? LFSR_SEED : value;
      end else if (advance) begin
         data <= step;
      end
   end

endmodule

// File: rtl/ram_fill_ctrl.sv
// Fills or verifies a contiguous, wrapping window of a single-port RAM.
// Verify compares ram_q against the issue-side pattern piped RD_LAT deep.
module ram_fill_ctrl
   import ram_fill_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter int                RD_LAT    = 2,
   parameter logic [DATA_W-1:0] LFSR_SEED = 'h1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              verify,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill_value,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr,
   output logic [ADDR_W:0]   err_count
);

   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

   state_e            state, state_nx;
   logic              verify_r;
   logic [ADDR_W:0]   rem;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   len_c;
   logic              accept, load, issue, advance, mismatch;

   logic              pv [RD_LAT];
   logic [ADDR_W-1:0] pa [RD_LAT];
   logic [DATA_W-1:0] pd [RD_LAT];

   assign len_c   = (length > DEPTH_L) ? DEPTH_L : length;
   assign accept  = (state == S_IDLE) && start;
   assign load    = accept && (len_c != '0);
   assign issue   = (state == S_RUN);
   assign advance = issue && (rem != ONE);

   assign busy        = (state != S_IDLE);
   assign done        = (state == S_FINISH);
   assign ram_wren    = issue && !verify_r;
   assign ram_address = addr_r;
   assign mismatch    = pv[RD_LAT-1] && (ram_q != pd[RD_LAT-1]);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (start) state_nx = (len_c == '0) ? S_FINISH : S_RUN;
         S_RUN:
            if (rem == ONE) state_nx = verify_r ? S_DRAIN : S_FINISH;
         S_DRAIN:
            if (rem == '0) state_nx = S_FINISH;
         S_FINISH:
            state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   // rem counts issues left in RUN, then drain cycles left in DRAIN
   always_ff @(posedge clock) begin
      if (reset) begin
         verify_r  <= 1'b0;
         rem       <= '0;
         addr_r    <= '0;
         error     <= 1'b0;
         err_addr  <= '0;
         err_count <= '0;
      end else begin
         if (accept) begin
            verify_r  <= verify;
            rem       <= len_c;
            error     <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
            if (load) addr_r <= base_addr;
         end else if (issue) begin
            rem <= (rem == ONE) ? (ADDR_W+1)'(RD_LAT - 1) : rem - ONE;
            if (advance) addr_r <= addr_r + ADDR_W'(1);
         end else if (state == S_DRAIN) begin
            rem <= rem - ONE;
         end
         if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ONE;
            if (!error) begin
               error    <= 1'b1;
               err_addr <= pa[RD_LAT-1];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < RD_LAT; k++) begin
            pv[k] <= 1'b0;
            pa[k] <= '0;
            pd[k] <= '0;
         end
      end else begin
         pv[0] <= issue && verify_r;
         pa[0] <= addr_r;
         pd[0] <= ram_data;
         for (int k = 1; k < RD_LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
            pd[k] <= pd[k-1];
         end
      end
   end

   ram_fill_pattern #(
      .DATA_W    (DATA_W),
      .LFSR_SEED (LFSR_SEED)
   ) u_pattern (
      .clock   (clock),
      .reset   (reset),
      .load    (load),
      .advance (advance),
      .mode    (mode),
      .value   (fill_value),
      .data    (ram_data)
   );

endmodule

// File: tb/tb_ram_fill_ctrl.sv
// Scoreboard bench for ram_fill_ctrl with a two-cycle-latency RAM model.
// Expected writes and done events are queued by the stimulus; a monitor pops them.
module tb_ram_fill_ctrl;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   typedef struct {
      int         cyc;
      bit         err;
      logic [7:0] ea;
      logic [8:0] ec;
   } done_t;

   logic       FPGA_CLK1_50;
   logic       reset, start, verify;
   logic [1:0] mode;
   logic [7:0] fill_value, base_addr;
   logic [8:0] length;
   logic       busy, done, ram_wren, error;
   logic [7:0] ram_address, ram_data, ram_q, err_addr;
   logic [8:0] err_count;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] ra;
   logic       mem_clr, poke_en;
   logic [7:0] poke_a, poke_v;

   wr_t        wq[$];
   done_t      dq[$];
   logic [7:0] wlog[$];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         n_done = 0;
   int         n_exp = 0;

   ram_fill_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RD_LAT    (RD_LAT),
      .LFSR_SEED (8'h01)
   ) dut (
      .clock       (FPGA_CLK1_50),
      .reset       (reset),
      .start       (start),
      .verify      (verify),
      .mode        (mode),
      .fill_value  (fill_value),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .error       (error),
      .err_addr    (err_addr),
      .err_count   (err_count)
   );

   initial FPGA_CLK1_50 = 1'b0;
   always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

   always @(posedge FPGA_CLK1_50) cyc <= cyc + 1;

   // registered address, registered q
   always @(posedge FPGA_CLK1_50) begin
      if (mem_clr) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
      end else begin
         if (poke_en) mem[poke_a] <= poke_v;
         if (ram_wren) mem[ram_address] <= ram_data;
      end
      ra    <= ram_address;
      ram_q <= mem[ra];
   end

   function automatic void chk(input string nm, input logic [63:0] got,
                               input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at cyc %0d", nm, got, want, cyc);
      end
   endfunction

   function automatic logic [7:0] pat_next(input logic [1:0] md,
                                           input logic [7:0] d);
      if (md == 2'd1) return d + 8'd1;
      if (md == 2'd2) return {1'b0, d[7:1]} ^ (d[0] ? 8'hB8 : 8'h00);
      return d;
   endfunction

   always @(negedge FPGA_CLK1_50) begin
      if (ram_wren) begin
         chk("wr_expected", wq.size() > 0, 1);
         if (wq.size() > 0) begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", ram_address, w.a);
            chk("wr_data", ram_data, w.d);
            wlog.push_back(ram_data);
         end
      end
      if (done) begin
         n_done++;
         chk("done_expected", dq.size() > 0, 1);
         if (dq.size() > 0) begin
            done_t e;
            e = dq.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_busy", busy, 1);
            chk("done_error", error, e.err);
            chk("done_err_addr", err_addr, e.ea);
            chk("done_err_count", err_count, e.ec);
            chk("done_wq_empty", wq.size(), 0);
         end
      end
   end

   task automatic corrupt(input logic [7:0] a, input logic [7:0] x);
      @(negedge FPGA_CLK1_50);
      poke_en    = 1'b1;
      poke_a     = a;
      poke_v     = ref_mem[a] ^ x;
      ref_mem[a] = ref_mem[a] ^ x;
      @(negedge FPGA_CLK1_50);
      poke_en = 1'b0;
   endtask

   task automatic do_pass(input bit vf, input logic [1:0] md,
                          input logic [7:0] fv, input logic [7:0] ba,
                          input int len, input int poke_at, input int rst_at);
      int         n, nw;
      logic [7:0] d, a;
      done_t      e;
      bit         fin;
      n  = (len > 256) ? 256 : len;
      nw = (rst_at >= 0 && rst_at < n) ? rst_at : n;
      d  = (md == 2'd2 && fv == 8'h00) ? 8'h01 : fv;
      e.err = 1'b0;
      e.ea  = '0;
      e.ec  = '0;
      for (int i = 0; i < n; i++) begin
         a = ba + 8'(i);
         if (vf) begin
            if (ref_mem[a] !== d) begin
               if (!e.err) e.ea = a;
               e.err = 1'b1;
               e.ec  = e.ec + 9'd1;
            end
         end else if (i < nw) begin
            wq.push_back('{a: a, d: d});
            ref_mem[a] = d;
         end
         d = pat_next(md, d);
      end
      wlog.delete();
      @(negedge FPGA_CLK1_50);
      #1;
      e.cyc = cyc + ((n == 0) ? 1 : n + 1 + (vf ? RD_LAT : 0));
      if (rst_at < 0) begin
         dq.push_back(e);
         n_exp++;
      end
      start      = 1'b1;
      verify     = vf;
      mode       = md;
      fill_value = fv;
      base_addr  = ba;
      length     = 9'(len);
      fin        = 1'b0;
      for (int c = 1; c <= 1000 && !fin; c++) begin
         @(negedge FPGA_CLK1_50);
         #1;
         start = (c == poke_at);
         if (c == poke_at) begin
            verify     = 1'($urandom);
            mode       = 2'($urandom);
            fill_value = 8'($urandom);
            base_addr  = 8'($urandom);
            length     = 9'($urandom_range(1, 300));
         end
         if (c == rst_at) begin
            reset = 1'b1;
            @(negedge FPGA_CLK1_50);
            #1;
            chk("rst_wren", ram_wren, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_addr", ram_address, 0);
            chk("rst_data", ram_data, 0);
            chk("rst_error", error, 0);
            chk("rst_err_count", err_count, 0);
            reset = 1'b0;
            fin   = 1'b1;
         end else if (rst_at < 0 && dq.size() == 0) begin
            fin = 1'b1;
         end
      end
      chk("pass_finished", fin, 1);
      @(negedge FPGA_CLK1_50);
      #1;
      start = 1'b0;
      chk("pass_wq_left", wq.size(), 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_wren", ram_wren, 0);
      chk("hold_error", error, e.err);
      chk("hold_err_count", err_count, e.ec);
      wq.delete();
      dq.delete();
   endtask

   initial begin
      logic [1:0] md;
      logic [7:0] fv, ba;
      int         ln, nc, dups, zeros;
      bit         seen [256];
      reset      = 1'b1;
      start      = 1'b0;
      verify     = 1'b0;
      mode       = 2'd0;
      fill_value = 8'h00;
      base_addr  = 8'h00;
      length     = 9'd0;
      poke_en    = 1'b0;
      poke_a     = 8'h00;
      poke_v     = 8'h00;
      mem_clr    = 1'b1;
      for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
      repeat (3) @(negedge FPGA_CLK1_50);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_wren", ram_wren, 0);
      chk("reset_addr", ram_address, 0);
      chk("reset_data", ram_data, 0);
      chk("reset_error", error, 0);
      chk("reset_err_addr", err_addr, 0);
      chk("reset_err_count", err_count, 0);
      mem_clr = 1'b0;
      reset   = 1'b0;

      do_pass(0, 2'd0, 8'hA5, 8'h00, 256, -1, -1);
      do_pass(1, 2'd0, 8'hA5, 8'h00, 256, -1, -1);

      corrupt(8'h07, 8'h3C);
      do_pass(1, 2'd0, 8'hA5, 8'h00, 20, -1, -1);
      do_pass(1, 2'd0, 8'hA5, 8'h00, 0, -1, -1);

      do_pass(0, 2'd1, 8'hFE, 8'd250, 10, -1, -1);
      chk("untouched_4", mem[4], 8'hA5);
      do_pass(1, 2'd1, 8'hFE, 8'd250, 10, -1, -1);

      do_pass(0, 2'd2, 8'h55, 8'h10, 0, -1, -1);

      for (int rep = 0; rep < 2; rep++) begin
         do_pass(0, 2'd2, 8'h00, 8'h00, 255, -1, -1);
         for (int k = 0; k < 256; k++) seen[k] = 1'b0;
         dups  = 0;
         zeros = 0;
         foreach (wlog[k]) begin
            if (wlog[k] == 8'h00) zeros++;
            if (seen[wlog[k]]) dups++;
            seen[wlog[k]] = 1'b1;
         end
         chk("lfsr_count", wlog.size(), 255);
         if (wlog.size() > 0) chk("lfsr_first", wlog[0], 8'h01);
         chk("lfsr_dups", dups, 0);
         chk("lfsr_zeros", zeros, 0);
      end
      do_pass(1, 2'd2, 8'h00, 8'h00, 255, -1, -1);

      do_pass(0, 2'd1, 8'h10, 8'h20, 30, 5, -1);
      do_pass(1, 2'd1, 8'h10, 8'h20, 12, 13, -1);
      do_pass(0, 2'd3, 8'h6B, 8'h80, 40, 41, -1);
      do_pass(0, 2'd1, 8'h33, 8'hC0, 300, -1, -1);

      do_pass(0, 2'd0, 8'h5A, 8'h40, 20, -1, 6);
      do_pass(1, 2'd0, 8'h5A, 8'h40, 20, -1, -1);
      do_pass(0, 2'd1, 8'h90, 8'h40, 8, -1, -1);

      for (int r = 0; r < 8; r++) begin
         md = 2'($urandom_range(0, 3));
         fv = 8'($urandom);
         ba = 8'($urandom);
         ln = $urandom_range(1, 300);
         do_pass(0, md, fv, ba, ln, -1, -1);
         nc = $urandom_range(0, 2);
         for (int k = 0; k < nc; k++)
            corrupt(ba + 8'($urandom_range(0, ((ln > 256) ? 256 : ln) - 1)),
                    8'($urandom_range(1, 255)));
         do_pass(1, md, fv, ba, ln, -1, -1);
      end

      chk("pass_count", n_done, n_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
